// File: rtl/voice_trans_cache_pkg.sv
// Shared defaults, readout state encoding and byte-select helper for the
// audio-to-Ethernet packet cache.
package voice_trans_cache_pkg;

    localparam int PKT_SAMPLES_DEF = 256;
    localparam int VS_LEN_DEF      = 4;
    localparam int VS_GAP_DEF      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VS   = 2'd1,
        GAP  = 2'd2,
        DATA = 2'd3
    } vtcState_e;

    // Packet bytes go out high byte first, so the even byte of a pair is [15:8].
    function automatic logic [7:0] sampleByte(input logic [15:0] sample, input logic lowHalf);
        return lowHalf ? sample[7:0] : sample[15:8];
    endfunction

endpackage

// File: rtl/voice_trans_cache_core_dpram.sv
// Simple dual-port sample store: one write port, one registered read port, one clock.
// The address MSB selects the ping-pong bank.
module voice_cache_dpram
    import voice_trans_cache_pkg::*;
#(
    parameter int DEPTH = 2 * PKT_SAMPLES_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/voice_trans_cache_core.sv
// Audio-to-Ethernet packet cache: captures one sample per dlrc period into a ping-pong
// buffer and replays each full bank as a vsync/href framed byte stream.
module voice_trans_cache_core
    import voice_trans_cache_pkg::*;
#(
    parameter int PKT_SAMPLES = PKT_SAMPLES_DEF,
    parameter int VS_LEN      = VS_LEN_DEF,
    parameter int VS_GAP      = VS_GAP_DEF
) (
    input  logic        sck,
    input  logic        rst,
    input  logic        dlrc,
    input  logic [15:0] ldata_in,
    output logic        voice_href,
    output logic        voice_vsync,
    output logic [7:0]  ldata_out
);

    localparam int AW = $clog2(PKT_SAMPLES);
    localparam int CW = $clog2(2 * PKT_SAMPLES) + 1;
    localparam logic [CW-1:0] VS_LAST   = CW'(VS_LEN - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(VS_GAP - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(2 * PKT_SAMPLES - 1);

    logic          dlrcS1_q, dlrcS2_q, dlrcDly_q, cap_q;
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic          wrBank_q, wrBank_d;
    logic          readyBank_q, readyBank_d;
    logic          curBank_q, curBank_d;
    logic          pending_q, pending_d;
    vtcState_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          href_d, vsync_d;
    logic [7:0]    dout_d;
    logic          wrap, startReq, enterVs;
    logic [AW-1:0] rdSample;
    logic [15:0]   rdData;

    assign wrap     = cap_q && (wrPtr_q == {AW{1'b1}});
    assign startReq = pending_q || wrap;
    assign enterVs  = (state_d == VS) && (state_q != VS);

    always_comb begin
        wrPtr_d     = cap_q ? wrPtr_q + 1'b1 : wrPtr_q;
        wrBank_d    = wrap ? ~wrBank_q : wrBank_q;
        readyBank_d = wrap ? wrBank_q : readyBank_q;
        curBank_d   = enterVs ? readyBank_d : curBank_q;
        // Starting a packet always consumes the newest ready bank; an older one is dropped.
        if (enterVs) begin
            pending_d = 1'b0;
        end else if (wrap) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (startReq) state_d = VS;
            end
            VS: begin
                if (cnt_q == VS_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = startReq ? VS : IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // The read address runs two bytes ahead of the output: one cycle of RAM latency plus
    // the output register. Outside DATA it parks on sample 0, ready for the first pair.
    assign rdSample = (state_q == DATA) ? AW'(cnt_q >> 1) + AW'(1) : '0;

    always_comb begin
        href_d  = (state_d == DATA);
        vsync_d = (state_d == VS);
        dout_d  = href_d ? sampleByte(rdData, cnt_d[0]) : 8'h00;
    end

    always_ff @(posedge sck or negedge rst) begin
        if (!rst) begin
            dlrcS1_q    <= 1'b0;
            dlrcS2_q    <= 1'b0;
            dlrcDly_q   <= 1'b0;
            cap_q       <= 1'b0;
            wrPtr_q     <= '0;
            wrBank_q    <= 1'b0;
            readyBank_q <= 1'b0;
            curBank_q   <= 1'b0;
            pending_q   <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            voice_href  <= 1'b0;
            voice_vsync <= 1'b0;
            ldata_out   <= 8'h00;
        end else begin
            dlrcS1_q    <= dlrc;
            dlrcS2_q    <= dlrcS1_q;
            dlrcDly_q   <= dlrcS2_q;
            cap_q       <= dlrcS2_q & ~dlrcDly_q;
            wrPtr_q     <= wrPtr_d;
            wrBank_q    <= wrBank_d;
            readyBank_q <= readyBank_d;
            curBank_q   <= curBank_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            voice_href  <= href_d;
            voice_vsync <= vsync_d;
            ldata_out   <= dout_d;
        end
    end

    voice_cache_dpram #(
        .DEPTH (2 * PKT_SAMPLES),
        .AW    (AW + 1)
    ) u_ram (
        .clk_i   (sck),
        .we_i    (cap_q),
        .waddr_i ({wrBank_q, wrPtr_q}),
        .wdata_i (ldata_in),
        .raddr_i ({curBank_q, rdSample}),
        .rdata_o (rdData)
    );

endmodule

// File: tb/tb_voice_trans_cache_core.sv
// Bench for voice_trans_cache_core: a nominal 16x instance checked against a queue of
// captured samples, plus a 4-sample instance at ratio 2 that must run back-to-back.
`timescale 1ns/1ps
module tb_voice_trans_cache_core;

    logic        sck      = 1'b0;
    logic        rst      = 1'b1;
    logic        dlrc     = 1'b0;
    logic        dlrc2    = 1'b0;
    logic [15:0] ldata_in = 16'd40;
    logic [15:0] ldata2   = 16'd0;
    logic        voice_href, voice_vsync, href2, vsync2;
    logic [7:0]  ldata_out, dout2;

    int checkCount = 0;
    int failCount  = 0;

    int          gp = 15;
    bit          randomMode = 1'b0;
    logic [15:0] capQ[$];

    int          pktCnt = 0, vsCnt = 0, byteCnt = 0, vsLen = 0, gapLen = 0;
    bit          inGap = 1'b0, prevVs = 1'b0, prevHref = 1'b0;
    logic [15:0] firstObs = 16'd0, relVal = 16'd0;
    bit          postReset = 1'b0;
    int          restartPkt = 0;

    int pendPkts = 0, pendVsLen = 0, pendHrefLen = 0;
    bit pPrevVs = 1'b0, pPrevHref = 1'b0;

    always #32 sck = ~sck;

    voice_trans_cache_core u_dut (
        .sck         (sck),
        .rst         (rst),
        .dlrc        (dlrc),
        .ldata_in    (ldata_in),
        .voice_href  (voice_href),
        .voice_vsync (voice_vsync),
        .ldata_out   (ldata_out)
    );

    voice_trans_cache_core #(.PKT_SAMPLES(4)) u_pend (
        .sck         (sck),
        .rst         (rst),
        .dlrc        (dlrc2),
        .ldata_in    (ldata2),
        .voice_href  (href2),
        .voice_vsync (vsync2),
        .ldata_out   (dout2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // dlrc at 16 sck per period; each rise seen while out of reset is one captured sample.
    initial begin
        forever begin
            @(posedge sck);
            #16;
            gp   = (gp + 1) % 16;
            dlrc = (gp < 8);
            if (gp == 0 && rst) capQ.push_back(ldata_in);
            if (gp == 8 && rst) ldata_in = randomMode ? 16'($urandom) : ldata_in + 16'd1;
        end
    end

    initial begin
        forever begin
            @(posedge sck);
            #16;
            dlrc2  = ~dlrc2;
            ldata2 = 16'($urandom);
        end
    end

    // Stream monitor for the nominal instance.
    initial begin
        logic [15:0] s;
        logic [7:0]  expByte;
        forever begin
            @(negedge sck);
            if (!rst) begin
                prevVs = 1'b0; prevHref = 1'b0; inGap = 1'b0;
                vsLen = 0; gapLen = 0; byteCnt = 0; vsCnt = pktCnt;
            end else begin
                checkOutput("vs_href_excl", voice_vsync & voice_href, 0);
                if (!voice_href) checkOutput("idle_byte", ldata_out, 0);
                if (voice_vsync && !prevVs) begin
                    vsCnt++;
                    checkOutput("vs_after_fill", capQ.size() >= 256, 1);
                    checkOutput("one_vs_per_pkt", vsCnt, pktCnt + 1);
                    vsLen = 0;
                end
                if (voice_vsync) vsLen++;
                if (!voice_vsync && prevVs) begin
                    checkOutput("vs_len", vsLen, 4);
                    inGap = 1'b1;
                    gapLen = 0;
                end
                if (inGap && !voice_vsync && !voice_href) gapLen++;
                if (voice_href && !prevHref) begin
                    checkOutput("gap_len", gapLen, 2);
                    inGap = 1'b0;
                    byteCnt = 0;
                end
                if (voice_href) begin
                    if (byteCnt >= 512) begin
                        checkOutput("pkt_overrun", byteCnt, 511);
                    end else if (capQ.size() <= byteCnt / 2) begin
                        checkOutput("pkt_model_short", capQ.size(), byteCnt / 2 + 1);
                    end else begin
                        s = capQ[byteCnt / 2];
                        expByte = (byteCnt % 2 == 1) ? s[7:0] : s[15:8];
                        checkOutput("pkt_byte", ldata_out, expByte);
                    end
                    if (byteCnt == 0) firstObs[15:8] = ldata_out;
                    if (byteCnt == 1) firstObs[7:0] = ldata_out;
                    byteCnt++;
                end
                if (!voice_href && prevHref) begin
                    checkOutput("href_len", byteCnt, 512);
                    if (!postReset) begin
                        checkOutput("ramp_start", firstObs, 16'(40 + 256 * pktCnt));
                    end else if (pktCnt == restartPkt) begin
                        checkOutput("restart_first", firstObs, relVal);
                    end
                    if (capQ.size() >= 256) begin
                        repeat (256) void'(capQ.pop_front());
                    end else begin
                        capQ.delete();
                    end
                    pktCnt++;
                end
                prevVs = voice_vsync;
                prevHref = voice_href;
            end
        end
    end

    // Monitor for the ratio-2 instance: every packet must be followed straight by vsync.
    initial begin
        forever begin
            @(negedge sck);
            if (!rst) begin
                pPrevVs = 1'b0; pPrevHref = 1'b0; pendVsLen = 0; pendHrefLen = 0;
            end else begin
                checkOutput("pend_excl", vsync2 & href2, 0);
                if (!href2) checkOutput("pend_idle_byte", dout2, 0);
                if (vsync2 && !pPrevVs) pendVsLen = 0;
                if (vsync2) pendVsLen++;
                if (!vsync2 && pPrevVs) checkOutput("pend_vs_len", pendVsLen, 4);
                if (href2 && !pPrevHref) pendHrefLen = 0;
                if (href2) pendHrefLen++;
                if (!href2 && pPrevHref) begin
                    checkOutput("pend_href_len", pendHrefLen, 8);
                    checkOutput("pend_b2b_vs", vsync2, 1);
                    pendPkts++;
                end
                pPrevVs = vsync2;
                pPrevHref = href2;
            end
        end
    end

    // Reset is held at least holdCycles and released with dlrc low, so the first capture
    // afterwards is the ldata_in value present at release.
    task automatic applyStimulus(input int holdCycles);
        rst = 1'b0;
        capQ.delete();
        #1;
        checkOutput("rst_vsync", voice_vsync, 0);
        checkOutput("rst_href", voice_href, 0);
        checkOutput("rst_byte", ldata_out, 0);
        checkOutput("rst_pend_href", href2, 0);
        repeat (holdCycles) @(posedge sck);
        #8;
        while (dlrc !== 1'b0) begin
            @(posedge sck);
            #8;
        end
        rst = 1'b1;
        relVal = ldata_in;
    endtask

    task automatic waitPackets(input int target, input int budget);
        int c = 0;
        while (pktCnt < target && c < budget) begin
            @(posedge sck);
            c++;
        end
        checkOutput("pkt_count", pktCnt, target);
    endtask

    initial begin
        int c;
        applyStimulus(9);
        waitPackets(5, 24000);
        c = 0;
        while (c < 6000) begin
            @(posedge sck);
            #8;
            if (pktCnt == 5 && voice_href && byteCnt == 100) break;
            c++;
        end
        checkOutput("mid_pkt_reached", byteCnt, 100);
        applyStimulus(3);
        postReset  = 1'b1;
        restartPkt = pktCnt;
        randomMode = 1'b1;
        waitPackets(7, 10000);
        checkOutput("pend_b2b_pkts", pendPkts >= 20, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
